// File: rtl/alu_defs.sv
// Shared encodings for the ALU control path: ALU op codes, MIPS opcode/funct
// values, immediate-extension selects and the registered EX control bundle.
package alu_defs;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_NOR  = 5'd5;
    localparam logic [4:0] ALU_SLL  = 5'd6;
    localparam logic [4:0] ALU_SRL  = 5'd7;
    localparam logic [4:0] ALU_SRA  = 5'd8;
    localparam logic [4:0] ALU_SLT  = 5'd9;
    localparam logic [4:0] ALU_NONE = 5'd10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [1:0] EXT_SIGN = 2'd0;
    localparam logic [1:0] EXT_ZERO = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [4:0] alu;
        logic       sign;
        logic       src1;
        logic       src2;
        logic [1:0] ext;
        logic [4:0] shamt;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_BUBBLE = '{
        valid: 1'b0, alu: ALU_NONE, sign: 1'b0, src1: 1'b0,
        src2: 1'b0, ext: EXT_SIGN, shamt: 5'd0
    };

endpackage

// File: rtl/alu_ctrl_decode.sv
// Zero-latency MIPS decode to ALU controls; legal_o=0 flags any opcode/funct
// pair the EX-stage ALU cannot execute.
module alu_ctrl_decode
    import alu_defs::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [4:0] alu_ctrl_o,
    output logic       sign_o,
    output logic       alu_src1_o,
    output logic       alu_src2_o,
    output logic [1:0] ext_op_o,
    output logic       legal_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        alu_ctrl_o = ALU_NONE;
        sign_o     = 1'b0;
        alu_src1_o = 1'b0;
        alu_src2_o = 1'b0;
        ext_op_o   = EXT_SIGN;
        legal_o    = 1'b1;

        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD:           begin alu_ctrl_o = ALU_ADD; sign_o = 1'b1; end
                    FN_ADDU:          alu_ctrl_o = ALU_ADD;
                    FN_SUB:           begin alu_ctrl_o = ALU_SUB; sign_o = 1'b1; end
                    FN_SUBU:          alu_ctrl_o = ALU_SUB;
                    FN_AND:           alu_ctrl_o = ALU_AND;
                    FN_OR:            alu_ctrl_o = ALU_OR;
                    FN_XOR:           alu_ctrl_o = ALU_XOR;
                    FN_NOR:           alu_ctrl_o = ALU_NOR;
                    FN_SLL:           begin alu_ctrl_o = ALU_SLL; alu_src1_o = 1'b1; end
                    FN_SRL:           begin alu_ctrl_o = ALU_SRL; alu_src1_o = 1'b1; end
                    FN_SRA:           begin alu_ctrl_o = ALU_SRA; alu_src1_o = 1'b1; end
                    FN_SLT:           begin alu_ctrl_o = ALU_SLT; sign_o = 1'b1; end
                    FN_SLTU:          alu_ctrl_o = ALU_SLT;
                    FN_JR, FN_JALR:   alu_ctrl_o = ALU_ADD;
                    default:          legal_o = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_ADDIU: begin
                alu_ctrl_o = ALU_ADD;
                alu_src2_o = 1'b1;
            end
            OP_ADDI: begin
                alu_ctrl_o = ALU_ADD;
                sign_o     = 1'b1;
                alu_src2_o = 1'b1;
            end
            OP_LUI: begin
                alu_ctrl_o = ALU_ADD;
                alu_src2_o = 1'b1;
                ext_op_o   = EXT_LUI;
            end
            OP_BEQ:   alu_ctrl_o = ALU_SUB;
            OP_ANDI: begin
                alu_ctrl_o = ALU_AND;
                alu_src2_o = 1'b1;
                ext_op_o   = EXT_ZERO;
            end
            OP_ORI: begin
                alu_ctrl_o = ALU_OR;
                alu_src2_o = 1'b1;
                ext_op_o   = EXT_ZERO;
            end
            OP_XORI: begin
                alu_ctrl_o = ALU_XOR;
                alu_src2_o = 1'b1;
                ext_op_o   = EXT_ZERO;
            end
            OP_SLTI: begin
                alu_ctrl_o = ALU_SLT;
                sign_o     = 1'b1;
                alu_src2_o = 1'b1;
            end
            OP_SLTIU: begin
                alu_ctrl_o = ALU_SLT;
                alu_src2_o = 1'b1;
            end
            OP_J, OP_JAL: alu_ctrl_o = ALU_NONE;
            default:      legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ID/EX register for ALU controls with flush > stall > load priority, plus a
// sticky illegal-instruction flag and saturating illegal counter.
module alu_ctrl_stage
    import alu_defs::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      instr,
    input  logic             stall,
    input  logic             flush,
    input  logic             clr_illegal,
    output logic             out_valid,
    output logic [4:0]       ALUCtrl,
    output logic             Sign,
    output logic             ALUSrc1,
    output logic             ALUSrc2,
    output logic [1:0]       ExtOp,
    output logic [4:0]       shamt_q,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [4:0] dec_alu;
    logic       dec_sign;
    logic       dec_src1;
    logic       dec_src2;
    logic [1:0] dec_ext;
    logic       dec_legal;

    ex_ctrl_t         ctrl_d, ctrl_q;
    logic             illegal_d, illegal_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             load_en;
    logic             illegal_load;

    // Register-number fields are consumed by the register file, not here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[25:11];

    alu_ctrl_decode u_decode (
        .opcode_i   (instr[31:26]),
        .funct_i    (instr[5:0]),
        .alu_ctrl_o (dec_alu),
        .sign_o     (dec_sign),
        .alu_src1_o (dec_src1),
        .alu_src2_o (dec_src2),
        .ext_op_o   (dec_ext),
        .legal_o    (dec_legal)
    );

    always_comb begin
        load_en      = !flush && !stall;
        illegal_load = load_en && in_valid && !dec_legal;

        ctrl_d = ctrl_q;
        if (flush) begin
            ctrl_d = EX_BUBBLE;
        end else if (!stall) begin
            if (in_valid && dec_legal) begin
                ctrl_d = '{valid: 1'b1, alu: dec_alu, sign: dec_sign, src1: dec_src1,
                           src2: dec_src2, ext: dec_ext, shamt: instr[10:6]};
            end else begin
                ctrl_d = EX_BUBBLE;
            end
        end

        // Clear beats a coincident illegal load; that event is intentionally lost.
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        if (clr_illegal) begin
            illegal_d = 1'b0;
            cnt_d     = '0;
        end else if (illegal_load) begin
            illegal_d = 1'b1;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q    <= EX_BUBBLE;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid   = ctrl_q.valid;
    assign ALUCtrl     = ctrl_q.alu;
    assign Sign        = ctrl_q.sign;
    assign ALUSrc1     = ctrl_q.src1;
    assign ALUSrc2     = ctrl_q.src2;
    assign ExtOp       = ctrl_q.ext;
    assign shamt_q     = ctrl_q.shamt;
    assign illegal     = illegal_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Bench for alu_ctrl_stage: table-driven reference model compared every cycle,
// directed literal checks, then randomized stall/flush/clear traffic.
module tb_alu_ctrl_stage;

    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [31:0]      instr;
    logic             stall;
    logic             flush;
    logic             clr_illegal;
    logic             out_valid;
    logic [4:0]       ALUCtrl;
    logic             Sign;
    logic             ALUSrc1;
    logic             ALUSrc2;
    logic [1:0]       ExtOp;
    logic [4:0]       shamt_q;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    alu_ctrl_stage #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .in_valid    (in_valid),
        .instr       (instr),
        .stall       (stall),
        .flush       (flush),
        .clr_illegal (clr_illegal),
        .out_valid   (out_valid),
        .ALUCtrl     (ALUCtrl),
        .Sign        (Sign),
        .ALUSrc1     (ALUSrc1),
        .ALUSrc2     (ALUSrc2),
        .ExtOp       (ExtOp),
        .shamt_q     (shamt_q),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    // Expected-decode tables indexed by funct (R-type) or opcode; -1 = illegal.
    int r_alu [64];
    int r_sign[64];
    int r_src1[64];
    int i_alu [64];
    int i_sign[64];
    int i_src2[64];
    int i_ext [64];

    task automatic set_r(input int f, input int alu, input int sg, input int s1);
        r_alu[f] = alu; r_sign[f] = sg; r_src1[f] = s1;
    endtask

    task automatic set_i(input int op, input int alu, input int sg, input int s2, input int ext);
        i_alu[op] = alu; i_sign[op] = sg; i_src2[op] = s2; i_ext[op] = ext;
    endtask

    initial begin
        for (int k = 0; k < 64; k++) begin
            r_alu[k] = -1; r_sign[k] = 0; r_src1[k] = 0;
            i_alu[k] = -1; i_sign[k] = 0; i_src2[k] = 0; i_ext[k] = 0;
        end
        set_r('h20, 0, 1, 0); set_r('h21, 0, 0, 0);
        set_r('h22, 1, 1, 0); set_r('h23, 1, 0, 0);
        set_r('h24, 2, 0, 0); set_r('h25, 3, 0, 0);
        set_r('h26, 4, 0, 0); set_r('h27, 5, 0, 0);
        set_r('h00, 6, 0, 1); set_r('h02, 7, 0, 1); set_r('h03, 8, 0, 1);
        set_r('h2A, 9, 1, 0); set_r('h2B, 9, 0, 0);
        set_r('h08, 0, 0, 0); set_r('h09, 0, 0, 0);
        set_i('h23, 0, 0, 1, 0); set_i('h2B, 0, 0, 1, 0);
        set_i('h08, 0, 1, 1, 0); set_i('h09, 0, 0, 1, 0);
        set_i('h0F, 0, 0, 1, 2); set_i('h04, 1, 0, 0, 0);
        set_i('h0C, 2, 0, 1, 1); set_i('h0D, 3, 0, 1, 1); set_i('h0E, 4, 0, 1, 1);
        set_i('h0A, 9, 1, 1, 0); set_i('h0B, 9, 0, 1, 0);
        set_i('h02, 10, 0, 0, 0); set_i('h03, 10, 0, 0, 0);
    end

    // Reference model state (reset values).
    logic       m_valid = 1'b0;
    logic [4:0] m_alu   = 5'd10;
    logic       m_sign  = 1'b0;
    logic       m_src1  = 1'b0;
    logic       m_src2  = 1'b0;
    logic [1:0] m_ext   = 2'd0;
    logic [4:0] m_shamt = 5'd0;
    logic       m_ill   = 1'b0;
    int         m_cnt   = 0;
    int e_alu, e_sign, e_s1, e_s2, e_ext, op_i, fn_i;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_alu = 5'd10; m_sign = 1'b0; m_src1 = 1'b0;
            m_src2 = 1'b0; m_ext = 2'd0; m_shamt = 5'd0; m_ill = 1'b0; m_cnt = 0;
        end else begin
            op_i = int'(instr[31:26]);
            fn_i = int'(instr[5:0]);
            if (op_i == 0) begin
                e_alu = r_alu[fn_i]; e_sign = r_sign[fn_i]; e_s1 = r_src1[fn_i]; e_s2 = 0; e_ext = 0;
            end else begin
                e_alu = i_alu[op_i]; e_sign = i_sign[op_i]; e_s1 = 0; e_s2 = i_src2[op_i]; e_ext = i_ext[op_i];
            end
            if (flush || (!stall && !(in_valid && e_alu >= 0))) begin
                m_valid = 1'b0; m_alu = 5'd10; m_sign = 1'b0; m_src1 = 1'b0;
                m_src2 = 1'b0; m_ext = 2'd0; m_shamt = 5'd0;
            end else if (!stall) begin
                m_valid = 1'b1; m_alu = 5'(e_alu); m_sign = 1'(e_sign); m_src1 = 1'(e_s1);
                m_src2 = 1'(e_s2); m_ext = 2'(e_ext); m_shamt = instr[10:6];
            end
            if (clr_illegal) begin
                m_ill = 1'b0; m_cnt = 0;
            end else if (in_valid && !stall && !flush && e_alu < 0) begin
                m_ill = 1'b1;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
        end
    end

    function automatic logic [31:0] dut_vec();
        return 32'({out_valid, ALUCtrl, Sign, ALUSrc1, ALUSrc2, ExtOp, shamt_q, illegal, illegal_cnt});
    endfunction

    function automatic logic [31:0] model_vec();
        return 32'({m_valid, m_alu, m_sign, m_src1, m_src2, m_ext, m_shamt, m_ill, CNT_W'(m_cnt)});
    endfunction

    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) check("model", dut_vec(), model_vec());
    end

    task automatic cyc(input logic v, input logic [31:0] ins, input logic st,
                       input logic fl, input logic cl);
        in_valid = v; instr = ins; stall = st; flush = fl; clr_illegal = cl;
        @(negedge clk);
    endtask

    localparam logic [31:0] I_ADD  = 32'h012A4020;
    localparam logic [31:0] I_SLTU = 32'h0109502B;
    localparam logic [31:0] I_SLL  = 32'h00094080;
    localparam logic [31:0] I_LUI  = 32'h3C01ABCD;
    localparam logic [31:0] I_ANDI = 32'h3128FFFF;
    localparam logic [31:0] I_SUB  = 32'h012A4022;
    localparam logic [31:0] I_ORI  = 32'h35280001;
    localparam logic [31:0] I_ILL  = 32'hFC000000;

    logic [5:0] op_list [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0A,
                                 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    logic [5:0] fn_list [15] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21,
                                 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

    initial begin
        logic [31:0] r;
        logic [31:0] ins;
        rst_n = 1'b0;
        in_valid = 1'b0; instr = '0; stall = 1'b0; flush = 1'b0; clr_illegal = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_alu", 32'(ALUCtrl), 32'd10);
        check("reset_cnt", 32'(illegal_cnt), 32'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        cyc(1, I_ADD, 0, 0, 0);
        check("add_alu", 32'(ALUCtrl), 32'd0);
        check("add_sign", 32'(Sign), 32'd1);
        check("add_valid", 32'(out_valid), 32'd1);
        cyc(1, I_SLTU, 0, 0, 0);
        check("sltu_alu", 32'(ALUCtrl), 32'd9);
        check("sltu_sign", 32'(Sign), 32'd0);
        cyc(1, I_SLL, 0, 0, 0);
        check("sll_alu", 32'(ALUCtrl), 32'd6);
        check("sll_src1", 32'(ALUSrc1), 32'd1);
        check("sll_shamt", 32'(shamt_q), 32'd2);
        cyc(1, I_LUI, 0, 0, 0);
        check("lui_alu", 32'(ALUCtrl), 32'd0);
        check("lui_src2", 32'(ALUSrc2), 32'd1);
        check("lui_ext", 32'(ExtOp), 32'd2);

        cyc(1, I_ANDI, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1, I_SUB, 1, 0, 0);
            check("stall_alu", 32'(ALUCtrl), 32'd2);
            check("stall_ext", 32'(ExtOp), 32'd1);
        end
        cyc(1, I_SUB, 0, 0, 0);
        check("unstall_alu", 32'(ALUCtrl), 32'd1);

        cyc(1, I_ORI, 1, 1, 0);
        check("flush_alu", 32'(ALUCtrl), 32'd10);
        check("flush_valid", 32'(out_valid), 32'd0);

        cyc(1, I_ILL, 0, 0, 0);
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_cnt", 32'(illegal_cnt), 32'd1);
        check("ill_valid", 32'(out_valid), 32'd0);
        cyc(1, I_ILL, 1, 0, 0);
        check("ill_stall_cnt", 32'(illegal_cnt), 32'd1);
        cyc(1, I_ILL, 0, 1, 0);
        check("ill_flush_cnt", 32'(illegal_cnt), 32'd1);
        repeat (4) cyc(1, I_ILL, 0, 0, 0);
        check("ill_saturate", 32'(illegal_cnt), 32'd3);
        cyc(1, I_ILL, 0, 0, 1);
        check("clr_flag", 32'(illegal), 32'd0);
        check("clr_cnt", 32'(illegal_cnt), 32'd0);

        // Asynchronous reset in the middle of the high phase.
        cyc(1, I_ILL, 0, 0, 0);
        in_valid = 1'b1; instr = I_ADD;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("areset_valid", 32'(out_valid), 32'd0);
        check("areset_alu", 32'(ALUCtrl), 32'd10);
        check("areset_cnt", 32'(illegal_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            r = $urandom();
            case ($urandom_range(0, 3))
                0: ins = {6'h00, r[25:0]};
                1: ins = {op_list[$urandom_range(0, 13)], r[25:0]};
                2: ins = r;
                default: ins = {6'h00, r[25:6], fn_list[$urandom_range(0, 14)]};
            endcase
            cyc($urandom_range(0, 9) < 8, ins, $urandom_range(0, 4) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
- ID/EX-side generator for the ALU control interface: decodes a MIPS instruction into the 5-bit ALU operation code, Sign flag and operand-select controls.
- Registers the decode into the ID/EX pipeline register with stall, flush and bubble handling.
- Also keeps a sticky illegal-instruction flag and a saturating illegal count for the exception/debug path.
- Sits between the decode stage and the EX-stage ALU, which it drives directly.

Parameters:
- CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; asserting it clears every register immediately.
- in_valid  input  1  ID stage holds a valid instruction.
- instr  input  32  instruction word: opcode [31:26], shamt [10:6], funct [5:0].
- stall  input  1  hazard unit freezes the ID/EX register.
- flush  input  1  branch/jump squash; inserts a bubble.
- clr_illegal  input  1  clears the sticky flag and the counter.
- out_valid  output  1  registered: EX slot holds a real instruction.
- ALUCtrl  output  5  registered ALU operation code, encoding below.
- Sign  output  1  registered: 1 = signed compare for code 9.
- ALUSrc1  output  1  registered: 1 = in1 is zero-extended shamt (shifts).
- ALUSrc2  output  1  registered: 1 = in2 is the extended immediate.
- ExtOp  output  2  registered: 0 = sign-ext, 1 = zero-ext, 2 = lui (imm<<16).
- shamt_q  output  5  registered shamt.
- illegal  output  1  sticky: an undecodable instruction was loaded.
- illegal_cnt  output  CNT_W  saturating count of illegal loads.

Behaviour:
- ALU code encoding: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 sll, 7 srl, 8 sra, 9 slt, 10 none/bubble.
- R-type decode (opcode 0):
  - funct 20/21h -> 0; 22/23h -> 1; 24h -> 2; 25h -> 3; 26h -> 4; 27h -> 5.
  - funct 00h -> 6, 02h -> 7, 03h -> 8, each with ALUSrc1=1.
  - funct 2Ah -> 9 with Sign=1; 2Bh -> 9 with Sign=0.
  - funct 08h/09h (jr/jalr) -> 0.
- I/J-type decode:
  - lw 23h, sw 2Bh, addi 08h, addiu 09h -> 0, ExtOp 0.
  - lui 0Fh -> 0, ExtOp 2.
  - beq 04h -> 1, ALUSrc2=0.
  - andi 0Ch -> 2, ori 0Dh -> 3, xori 0Eh -> 4, each ExtOp 1.
  - slti 0Ah -> 9 Sign=1; sltiu 0Bh -> 9 Sign=0.
  - j 02h / jal 03h -> 10.
  - All I-types except beq set ALUSrc2=1.
- Sign=1 for add/sub/addi/slt/slti; otherwise 0.
- Any other opcode/funct combination is illegal: load code 10 with out_valid=0, set illegal, and increment illegal_cnt.
- The combinational decode block has zero latency; outputs are registered, so pipeline latency is 1 cycle.
- Register update priority, evaluated each rising edge:
  - flush: load a bubble (out_valid=0, ALUCtrl=10, all other controls 0).
  - else stall: hold every output.
  - else: load the decode of instr, with out_valid=in_valid.
- flush and stall together: flush wins and a bubble is loaded.
- in_valid=0 with no stall loads a bubble.
- Illegal detection counts only on an actual load, i.e. in_valid=1, no stall, no flush. A stalled or flushed illegal instruction does not count.
- illegal_cnt saturates at 2^CNT_W-1 and does not wrap.
- clr_illegal clears the flag and the counter. If clr_illegal coincides with an illegal load, clear wins; that event is lost.
- Reset values: out_valid=0, ALUCtrl=10, Sign=0, ALUSrc1=0, ALUSrc2=0, ExtOp=0, shamt_q=0, illegal=0, illegal_cnt=0.
- A reset assertion mid-operation returns every register to these values asynchronously. The first load after deassertion happens on the next clk edge.

Decomposition:
- Shared package alu_defs holds:
  - ALU code constants (ALU_ADD … ALU_NONE=10).
  - Opcode and funct constants.
  - ExtOp constants.
- Sub-module alu_ctrl_decode: pure combinational instr -> {ALUCtrl, Sign, ALUSrc1, ALUSrc2, ExtOp, legal}. It is reusable by the ALU self-test bench.
- alu_ctrl_stage contains only the registers, the stall/flush priority logic and the counters.

Test Plan:
- Reset: assert reset low mid-cycle with a valid instr loaded -> all outputs go to reset values immediately (ALUCtrl=10, out_valid=0, illegal_cnt=0).
- Decode sweep, one instruction per cycle, no stall:
  - instr 0x012A4020 (add) -> ALUCtrl 0, Sign 1, out_valid 1 on the next edge.
  - 0x0109502B (sltu) -> 9, Sign 0.
  - 0x00094080 (sll $8,$9,2) -> 6, ALUSrc1 1, shamt_q 2.
  - 0x3C01ABCD (lui) -> 0, ALUSrc2 1, ExtOp 2.
- Stall: load andi 0x3128FFFF (code 2, ExtOp 1), then stall=1 for 3 cycles while instr changes to sub -> outputs hold 2/1; after stall drops, the next edge shows code 1.
- Flush with stall: stall=1, flush=1 simultaneously while ori is presented -> bubble (ALUCtrl 10, out_valid 0).
- Illegal: instr 0xFC000000 loaded -> illegal=1, illegal_cnt=1, out_valid=0. The same instr held under stall or flush leaves the count unchanged.
- Counter: with CNT_W=2, load 5 illegal instructions -> count saturates at 3. Then assert clr_illegal together with a sixth illegal load -> illegal=0, illegal_cnt=0.
